uart_rx_fsm: RTL and testbench

- Receive-side frame controller for the UART RX path; sits directly upstream of the parity checker.
- Detects and validates the start bit using 16x oversampled baud ticks.
- Generates the frame state code, mid-bit sample strobe, assembled data word, frame-error flag and receive-valid pulse.
- The parity checker consumes o_p_state, o_count_full and the same i_rx_in/i_baud.

---
 rtl/uart_rx_pkg.sv | 37 +++
 rtl/rx_sample_counter.sv | 27 ++
 rtl/uart_rx_fsm.sv | 127 ++++++++++++
 tb/tb_uart_rx_fsm.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: frame state codes (also decoded
// by the parity checker), data-length encodings and the default oversample rate.
package uart_rx_pkg;

    localparam int OVERSAMPLE_DEF = 16;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        START    = 3'b001,
        RECEIVER = 3'b010,
        PARITY   = 3'b011,
        STOP_I   = 3'b100,
        STOP_II  = 3'b101
    } rx_state_e;

    typedef struct packed {
        logic [1:0] data_bits;
        logic       stop_bits;
        logic       parity_en;
    } rx_cfg_t;

    function automatic int data_len(input logic [1:0] bits);
        case (bits)
            DBITS_5: return 5;
            DBITS_6: return 6;
            DBITS_7: return 7;
            DBITS_8: return 8;
            default: return 8;
        endcase
    endfunction

endpackage

// File: rtl/rx_sample_counter.sv
// Oversample tick counter: counts enabled ticks, wraps after OVERSAMPLE-1 and
// flags the full (mid-bit) point. Shared with the transmit side.
module rx_sample_counter #(
    parameter int OVERSAMPLE = 16,
    parameter int CW         = $clog2(OVERSAMPLE)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_enable,
    output logic [CW-1:0] o_count,
    output logic          o_count_full
);

    assign o_count_full = (o_count == CW'(OVERSAMPLE - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_count <= '0;
        end else if (i_clear) begin
            o_count <= '0;
        end else if (i_enable) begin
            o_count <= o_count_full ? '0 : o_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: validates the start bit at its midpoint, then
// samples data, optional parity and stop bits once per bit at the mid-bit strobe.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_W     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_baud,
    input  logic              i_rx_in,
    input  logic [1:0]        i_data_bits,
    input  logic              i_stop_bits,
    input  logic              i_parity_en,
    output logic [2:0]        o_p_state,
    output logic              o_count_full,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_frame_err,
    output logic              o_busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_W);

    rx_state_e         state;
    rx_cfg_t           cfg;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] data_reg;
    logic              err_reg;
    logic [CW-1:0]     tick_cnt;
    logic              count_full;
    logic              mid_start;
    logic              tick_clear;
    logic              strobe;
    logic [BW-1:0]     last_idx;

    // The counter is parked at zero in IDLE so the start-bit half-period is
    // measured from the detecting tick, and restarts when the start bit is judged.
    assign mid_start  = i_baud && (tick_cnt == CW'(OVERSAMPLE / 2 - 1));
    assign tick_clear = (state == IDLE) || ((state == START) && mid_start);
    assign strobe     = i_baud && count_full;
    assign last_idx   = BW'(data_len(cfg.data_bits) - 1);

    rx_sample_counter #(
        .OVERSAMPLE (OVERSAMPLE),
        .CW         (CW)
    ) u_tick_counter (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (tick_clear),
        .i_enable     (i_baud),
        .o_count      (tick_cnt),
        .o_count_full (count_full)
    );

    assign o_p_state    = state;
    assign o_count_full = count_full;
    assign o_busy       = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cfg         <= '0;
            bit_cnt     <= '0;
            data_reg    <= '0;
            err_reg     <= 1'b0;
            o_rx_data   <= '0;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cfg <= '{data_bits: i_data_bits, stop_bits: i_stop_bits, parity_en: i_parity_en};
                    if (i_baud && !i_rx_in) state <= START;
                end
                START: begin
                    if (mid_start) begin
                        if (!i_rx_in) begin
                            state    <= RECEIVER;
                            bit_cnt  <= '0;
                            data_reg <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                RECEIVER: begin
                    if (strobe) begin
                        data_reg[bit_cnt] <= i_rx_in;
                        bit_cnt           <= bit_cnt + 1'b1;
                        if (bit_cnt == last_idx) state <= cfg.parity_en ? PARITY : STOP_I;
                    end
                end
                PARITY: begin
                    if (strobe) state <= STOP_I;
                end
                // Frames finish at mid-stop-bit so a back-to-back start edge is never missed.
                STOP_I: begin
                    if (strobe) begin
                        if (cfg.stop_bits) begin
                            err_reg <= ~i_rx_in;
                            state   <= STOP_II;
                        end else begin
                            state       <= IDLE;
                            o_rx_data   <= data_reg;
                            o_frame_err <= ~i_rx_in;
                            o_rx_valid  <= 1'b1;
                        end
                    end
                end
                STOP_II: begin
                    if (strobe) begin
                        state       <= IDLE;
                        o_rx_data   <= data_reg;
                        o_frame_err <= err_reg | ~i_rx_in;
                        o_rx_valid  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: drives serial frames at 16x oversampling and
// checks state walk, strobes, data, frame error, valid timing and reset abort.
module tb_uart_rx_fsm;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_baud = 1'b0;
    logic       i_rx_in = 1'b1;
    logic [1:0] i_data_bits = 2'b11;
    logic       i_stop_bits = 1'b0;
    logic       i_parity_en = 1'b0;
    logic [2:0] o_p_state;
    logic       o_count_full;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_frame_err;
    logic       o_busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    int         tick_total = 0;
    int         recv_strobes = 0;
    int         log_len = 0;
    logic [2:0] state_log [0:255];
    logic [2:0] last_state = 3'b000;
    int         vcount = 0;
    int         vtick [0:63];
    logic [7:0] vdata [0:63];
    logic       verr  [0:63];

    uart_rx_fsm #(.OVERSAMPLE(16), .DATA_W(8)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_baud       (i_baud),
        .i_rx_in      (i_rx_in),
        .i_data_bits  (i_data_bits),
        .i_stop_bits  (i_stop_bits),
        .i_parity_en  (i_parity_en),
        .o_p_state    (o_p_state),
        .o_count_full (o_count_full),
        .o_rx_data    (o_rx_data),
        .o_rx_valid   (o_rx_valid),
        .o_frame_err  (o_frame_err),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // One baud tick every third clock, so the FSM must also hold between ticks.
    initial begin
        int div = 0;
        forever begin
            @(posedge i_clk);
            #2;
            i_baud = (div == 0);
            div = (div == 2) ? 0 : div + 1;
        end
    end

    // Observers sample mid-cycle, where inputs and outputs are both settled.
    always @(negedge i_clk) begin
        if (o_p_state !== last_state) begin
            if (log_len < 256) state_log[log_len] = o_p_state;
            log_len++;
            last_state = o_p_state;
        end
        if (i_baud && o_count_full && o_p_state == 3'b010) recv_strobes++;
        if (o_rx_valid) begin
            if (vcount < 64) begin
                vtick[vcount] = tick_total;
                vdata[vcount] = o_rx_data;
                verr[vcount]  = o_frame_err;
            end
            vcount++;
        end
        if (i_baud) tick_total++;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_tick();
        int guard = 0;
        @(negedge i_clk);
        while (i_baud !== 1'b1 && guard < 100) begin
            @(negedge i_clk);
            guard++;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int n);
        i_rx_in = v;
        repeat (n) wait_tick();
    endtask

    // Sends one frame; the config inputs are scrambled mid-frame to prove they are latched.
    task automatic applyStimulus(input logic [7:0] data, input int nbits, input bit par_en,
                                 input logic stop_val, input int nstop);
        logic [1:0] db = i_data_bits;
        logic       sb = i_stop_bits;
        logic       pe = i_parity_en;
        logic       par = 1'b0;
        drive_bit(1'b0, 1);
        i_data_bits = ~db;
        i_stop_bits = ~sb;
        i_parity_en = ~pe;
        drive_bit(1'b0, 15);
        for (int i = 0; i < nbits; i++) begin
            par ^= data[i];
            drive_bit(data[i], 16);
        end
        if (par_en) drive_bit(par, 16);
        for (int s = 0; s < nstop; s++) drive_bit(stop_val, 16);
        i_rx_in = 1'b1;
        i_data_bits = db;
        i_stop_bits = sb;
        i_parity_en = pe;
    endtask

    function automatic logic [23:0] pack_log(input int start, input int n);
        logic [23:0] p = '0;
        for (int i = 0; i < n; i++) p = {p[20:0], state_log[start + i]};
        return p;
    endfunction

    initial begin
        int lg, vc, rs;

        repeat (4) @(negedge i_clk);
        checkOutput("reset_state", 32'(o_p_state), 32'h0);
        checkOutput("reset_data", 32'(o_rx_data), 32'h0);
        checkOutput("reset_valid", 32'(o_rx_valid), 32'h0);
        checkOutput("reset_ferr", 32'(o_frame_err), 32'h0);
        checkOutput("reset_busy", 32'(o_busy), 32'h0);
        checkOutput("reset_cfull", 32'(o_count_full), 32'h0);
        i_rst_n = 1'b1;
        drive_bit(1'b1, 20);

        $display("[TB] 8N1 frame 0xA5");
        i_data_bits = 2'b11; i_stop_bits = 1'b0; i_parity_en = 1'b0;
        lg = log_len; vc = vcount; rs = recv_strobes;
        applyStimulus(8'hA5, 8, 1'b0, 1'b1, 1);
        drive_bit(1'b1, 4);
        checkOutput("8n1_data", 32'(o_rx_data), 32'hA5);
        checkOutput("8n1_ferr", 32'(o_frame_err), 32'h0);
        checkOutput("8n1_valid_cycles", 32'(vcount - vc), 32'h1);
        checkOutput("8n1_strobes", 32'(recv_strobes - rs), 32'h8);
        checkOutput("8n1_state_changes", 32'(log_len - lg), 32'h4);
        checkOutput("8n1_state_walk", 32'(pack_log(lg, 4)), 32'b001_010_100_000);
        checkOutput("8n1_busy_after", 32'(o_busy), 32'h0);

        $display("[TB] 7E2 frame 0x3C");
        i_data_bits = 2'b10; i_stop_bits = 1'b1; i_parity_en = 1'b1;
        drive_bit(1'b1, 4);
        lg = log_len; vc = vcount; rs = recv_strobes;
        applyStimulus(8'h3C, 7, 1'b1, 1'b1, 2);
        drive_bit(1'b1, 4);
        checkOutput("7e2_data", 32'(o_rx_data), 32'h3C);
        checkOutput("7e2_ferr", 32'(o_frame_err), 32'h0);
        checkOutput("7e2_valid_cycles", 32'(vcount - vc), 32'h1);
        checkOutput("7e2_strobes", 32'(recv_strobes - rs), 32'h7);
        checkOutput("7e2_state_walk", 32'(pack_log(lg, 6)), 32'b001_010_011_100_101_000);

        $display("[TB] 5N1 frames 0x15 with bad stop, then 0x0A");
        i_data_bits = 2'b00; i_stop_bits = 1'b0; i_parity_en = 1'b0;
        drive_bit(1'b1, 4);
        vc = vcount;
        applyStimulus(8'h15, 5, 1'b0, 1'b0, 1);
        drive_bit(1'b1, 16);
        checkOutput("5n1_err_valid_cycles", 32'(vcount - vc), 32'h1);
        checkOutput("5n1_err_data", 32'(vdata[vc]), 32'h15);
        checkOutput("5n1_err_flag", 32'(o_frame_err), 32'h1);
        checkOutput("5n1_retrigger_idle", 32'(o_p_state), 32'h0);
        vc = vcount;
        applyStimulus(8'h0A, 5, 1'b0, 1'b1, 1);
        drive_bit(1'b1, 4);
        checkOutput("5n1_clean_valid_cycles", 32'(vcount - vc), 32'h1);
        checkOutput("5n1_clean_data", 32'(o_rx_data), 32'h0A);
        checkOutput("5n1_clean_ferr", 32'(o_frame_err), 32'h0);

        $display("[TB] glitch on idle line");
        i_data_bits = 2'b11;
        vc = vcount;
        drive_bit(1'b0, 4);
        checkOutput("glitch_start_state", 32'(o_p_state), 32'h1);
        checkOutput("glitch_busy_high", 32'(o_busy), 32'h1);
        drive_bit(1'b1, 12);
        checkOutput("glitch_back_idle", 32'(o_p_state), 32'h0);
        checkOutput("glitch_busy_low", 32'(o_busy), 32'h0);
        checkOutput("glitch_no_valid", 32'(vcount - vc), 32'h0);
        checkOutput("glitch_data_kept", 32'(o_rx_data), 32'h0A);

        $display("[TB] reset during RECEIVER");
        vc = vcount;
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 8);
        checkOutput("abort_in_receiver", 32'(o_p_state), 32'h2);
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("abort_state", 32'(o_p_state), 32'h0);
        checkOutput("abort_data", 32'(o_rx_data), 32'h0);
        checkOutput("abort_busy", 32'(o_busy), 32'h0);
        checkOutput("abort_valid", 32'(o_rx_valid), 32'h0);
        i_rx_in = 1'b1;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        drive_bit(1'b1, 8);
        checkOutput("abort_no_valid", 32'(vcount - vc), 32'h0);
        applyStimulus(8'hFF, 8, 1'b0, 1'b1, 1);
        drive_bit(1'b1, 4);
        checkOutput("after_reset_data", 32'(o_rx_data), 32'hFF);
        checkOutput("after_reset_valid_cycles", 32'(vcount - vc), 32'h1);

        $display("[TB] back-to-back 8N1 frames 0x55, 0xAA");
        vc = vcount;
        applyStimulus(8'h55, 8, 1'b0, 1'b1, 1);
        applyStimulus(8'hAA, 8, 1'b0, 1'b1, 1);
        drive_bit(1'b1, 4);
        checkOutput("b2b_valid_cycles", 32'(vcount - vc), 32'h2);
        checkOutput("b2b_first_data", 32'(vdata[vc]), 32'h55);
        checkOutput("b2b_second_data", 32'(vdata[vc + 1]), 32'hAA);
        checkOutput("b2b_spacing_ticks", 32'(vtick[vc + 1] - vtick[vc]), 32'd160);
        checkOutput("b2b_ferr", 32'(verr[vc + 1]), 32'h0);

        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
